// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with count, programmable flags, error pulses, flush and FWFT mode
module sync_fifo_prog #(
    parameter int DATA_WIDTH            = 8,
    parameter int MEM_DEPTH             = 16,
    parameter int number_of_bit_address = 4,
    parameter int AF_LEVEL              = 12,
    parameter int AE_LEVEL              = 2,
    parameter int FWFT                  = 0
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             FLUSH,
    input  logic [DATA_WIDTH-1:0]            WR_DATA,
    input  logic                             W_INC,
    input  logic                             R_INC,
    output logic [DATA_WIDTH-1:0]            RD_DATA,
    output logic                             RD_VALID,
    output logic                             FULL,
    output logic                             EMPTY,
    output logic                             ALMOST_FULL,
    output logic                             ALMOST_EMPTY,
    output logic [number_of_bit_address:0]   COUNT,
    output logic                             OVERFLOW,
    output logic                             UNDERFLOW
);

    localparam int AW = number_of_bit_address;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(MEM_DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    // Elaboration-time rejection of inconsistent parameter sets
    if (MEM_DEPTH != (1 << number_of_bit_address)) begin : g_bad_depth
        $fatal(1, "sync_fifo_prog: MEM_DEPTH must equal 2**number_of_bit_address");
    end
    if (AE_LEVEL < 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_prog: AE_LEVEL must be at least 1");
    end
    if ((AF_LEVEL <= AE_LEVEL) || (AF_LEVEL > MEM_DEPTH - 1)) begin : g_bad_af
        $fatal(1, "sync_fifo_prog: AF_LEVEL must satisfy AE_LEVEL < AF_LEVEL <= MEM_DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $fatal(1, "sync_fifo_prog: FWFT must be 0 or 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "sync_fifo_prog: DATA_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [AW:0]           count_q;
    logic [AW:0]           count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  live;

    // Requests are qualified only by registered flags, so no request reaches a flag combinationally
    assign live   = ~RST & ~FLUSH;
    assign wr_acc = W_INC & ~full_q;
    assign rd_acc = R_INC & ~empty_q;

    // Occupancy after this edge when neither reset nor flush applies
    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - 1'b1;
        end
    end

    // Storage array is never cleared; writes are suppressed during reset and flush
    always_ff @(posedge CLK) begin
        if (live && wr_acc) begin
            mem[wptr_q] <= WR_DATA;
        end
    end

    // Pointers, occupancy, flags and error pulses
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == DEPTH_C);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= AF_C);
            aempty_q <= (count_nxt <= AE_C);
            ovf_q    <= W_INC & full_q;
            unf_q    <= R_INC & empty_q;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented straight from the array while anything is stored
        assign RD_DATA  = mem[rptr_q];
        assign RD_VALID = ~empty_q;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        // Registered read: data appears one cycle after an accepted read; flush keeps the data
        always_ff @(posedge CLK) begin
            if (RST) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (FLUSH) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rptr_q];
                end
            end
        end

        assign RD_DATA  = rd_data_q;
        assign RD_VALID = rd_valid_q;
    end

    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - scoreboard bench for sync_fifo_prog in registered and FWFT read modes
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int AEL   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          w_inc = 1'b0;
    logic          r_inc = 1'b0;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0]    count0, count1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .number_of_bit_address(4),
                     .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) dut0 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .WR_DATA(wr_data), .W_INC(w_inc), .R_INC(r_inc),
        .RD_DATA(rd_data0), .RD_VALID(rd_valid0), .FULL(full0), .EMPTY(empty0),
        .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0), .COUNT(count0),
        .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .number_of_bit_address(4),
                     .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) dut1 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .WR_DATA(wr_data), .W_INC(w_inc), .R_INC(r_inc),
        .RD_DATA(rd_data1), .RD_VALID(rd_valid1), .FULL(full1), .EMPTY(empty1),
        .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1), .COUNT(count1),
        .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every registered-mode read result must match the oldest expected word
    always @(negedge clk) begin
        if (rd_valid0 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_spurious: got data %0h with nothing expected at %0t", rd_data0, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data0 !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %0h expected %0h at %0t", rd_data0, e, $time);
                end
            end
        end
    end

    // One clock of stimulus; the reference model is a plain queue of stored words
    task automatic step(input logic s_rst, input logic s_flush, input logic w,
                        input logic r, input logic [DW-1:0] d);
        int  sz;
        int  n;
        bit  ovf_e, unf_e;
        rst = s_rst; flush = s_flush; w_inc = w; r_inc = r; wr_data = d;
        sz = mdl.size();
        ovf_e = 1'b0;
        unf_e = 1'b0;
        if (s_rst || s_flush) begin
            mdl.delete();
        end else begin
            ovf_e = w && (sz == DEPTH);
            unf_e = r && (sz == 0);
            if (r && sz > 0) exp_q.push_back(mdl.pop_front());
            if (w && sz < DEPTH) mdl.push_back(d);
        end
        n = mdl.size();
        @(posedge clk);
        #1;
        chk("count", int'(count0), n);
        chk("full", int'(full0), int'(n == DEPTH));
        chk("empty", int'(empty0), int'(n == 0));
        chk("almost_full", int'(af0), int'(n >= AFL));
        chk("almost_empty", int'(ae0), int'(n <= AEL));
        chk("overflow", int'(ovf0), int'(ovf_e));
        chk("underflow", int'(unf0), int'(unf_e));
        chk("fwft_count", int'(count1), n);
        chk("fwft_valid", int'(rd_valid1), int'(n > 0));
        if (n > 0) chk("fwft_data", int'(rd_data1), int'(mdl[0]));
        @(negedge clk);
    endtask

    initial begin
        int pw, pr;
        @(negedge clk);

        // Reset
        step(1, 0, 0, 0, 8'h00);
        chk("reset_rd_valid", int'(rd_valid0), 0);
        chk("reset_rd_data", int'(rd_data0), 0);

        // Fill to full, then one rejected write of 0xAA
        for (int i = 1; i <= 16; i++) step(0, 0, 1, 0, DW'(i));
        step(0, 0, 1, 0, 8'hAA);

        // Drain, then one rejected read
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Simultaneous requests when full, then when empty
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, DW'(8'h30 + i));
        step(0, 0, 1, 1, 8'hBB);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 1, 8'hC3);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Steady state at occupancy 5 across pointer wrap
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, DW'(8'h60 + i));
        for (int i = 0; i < 40; i++) step(0, 0, 1, 1, DW'($urandom));

        // Flush with 7 words and a concurrent write, then one word through FWFT
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, DW'(8'h70 + i));
        step(0, 1, 1, 0, 8'hEE);
        step(0, 0, 1, 0, 8'h5A);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);

        // Randomized traffic with phases biased towards full or empty
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                pw = $urandom_range(10, 90);
                pr = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), DW'($urandom));
        end

        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("rd_pending_at_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
